output_data_buffer: RTL and testbench

- Output-side stage directly downstream of the processor top level.
- Captures each 16-bit Output_Data word the processor publishes (qualified by a write strobe) into a small FIFO.
- Presents buffered words to an external consumer (display driver, UART bridge, test monitor) over a valid/ready handshake.
- Decouples processor execution from a slower or stalling consumer and flags lost words.

---
 rtl/processor_pkg.sv | 11 +
 rtl/output_buffer_ram.sv | 35 +++
 rtl/output_data_buffer.sv | 142 ++++++++++++++
 tb/tb_output_data_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared processor-side constants used by the output data buffer.
package processor_pkg;

    // Width of the processor Output_Data bus.
    localparam int unsigned DATA_WIDTH     = 16;
    // Default number of entries in the output buffer FIFO.
    localparam int unsigned OUT_BUF_DEPTH  = 8;
    // Width of the saturating dropped-word counter.
    localparam int unsigned DROP_CNT_WIDTH = 8;

endpackage : processor_pkg

// File: rtl/output_buffer_ram.sv
// Storage array for the output data buffer: synchronous write, asynchronous read.
// Ports:
//   clk      - write clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data (combinational from rd_addr)
module output_buffer_ram
    import processor_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = processor_pkg::DATA_WIDTH,
    parameter int unsigned  DEPTH      = processor_pkg::OUT_BUF_DEPTH,
    localparam int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : output_buffer_ram

// File: rtl/output_data_buffer.sv
// Show-ahead FIFO capturing processor Output_Data words for a valid/ready consumer.
// Optional feature macro: OUTPUT_BUFFER_DROP_COUNT_EN (adds a saturating Drop_Count).
// Ports:
//   Clock, Reset_n - clock and asynchronous active-low reset
//   In_Data, In_Write - processor word and its write strobe
//   In_Full        - FIFO holds DEPTH entries
//   Out_Data, Out_Valid, Out_Ready - consumer handshake (Out_Data is 0 when empty)
//   Count          - occupancy 0..DEPTH
//   Overflow       - sticky: at least one word was dropped
//   Clear          - synchronous flush, highest priority
//   Drop_Count     - (macro only) saturating count of dropped words
module output_data_buffer
#(
    parameter int unsigned  DATA_WIDTH = processor_pkg::DATA_WIDTH,
    parameter int unsigned  DEPTH      = processor_pkg::OUT_BUF_DEPTH,
    localparam int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Write,
    output logic                  In_Full,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [PTR_WIDTH:0]    Count,
    output logic                  Overflow,
`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
    output logic [processor_pkg::DROP_CNT_WIDTH-1:0] Drop_Count,
`endif
    input  logic                  Clear
);

    import processor_pkg::*;

    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  pop_c;
    logic                  push_c;
    logic                  drop_c;

    // Handshake decode; a pop at full frees the slot the same-cycle push uses.
    always_comb begin
        pop_c  = Out_Valid && Out_Ready && !Clear;
        push_c = In_Write && (!In_Full || pop_c) && !Clear;
        drop_c = In_Write && In_Full && !pop_c && !Clear;
    end

    // Next occupancy; Clear overrides any push/pop.
    always_comb begin
        count_next = count;
        if (Clear) begin
            count_next = '0;
        end else if (push_c && !pop_c) begin
            count_next = count + CNT_WIDTH'(1);
        end else if (pop_c && !push_c) begin
            count_next = count - CNT_WIDTH'(1);
        end
    end

    // Pointers, occupancy and the registered flags derived from it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            In_Full   <= 1'b0;
            Out_Valid <= 1'b0;
        end else begin
            if (Clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            count     <= count_next;
            In_Full   <= (count_next == CNT_WIDTH'(DEPTH));
            Out_Valid <= (count_next != '0);
        end
    end

`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_count;
    logic [DROP_CNT_WIDTH-1:0] drop_count_next;

    // Saturating drop counter; Overflow is simply "any drops recorded".
    always_comb begin
        drop_count_next = drop_count;
        if (Clear) begin
            drop_count_next = '0;
        end else if (drop_c && (drop_count != '1)) begin
            drop_count_next = drop_count + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            drop_count <= '0;
            Overflow   <= 1'b0;
        end else begin
            drop_count <= drop_count_next;
            Overflow   <= (drop_count_next != '0);
        end
    end

    assign Drop_Count = drop_count;
`else
    // Sticky overflow flag.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Overflow <= 1'b0;
        end else if (Clear) begin
            Overflow <= 1'b0;
        end else if (drop_c) begin
            Overflow <= 1'b1;
        end
    end
`endif

    output_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (Clock),
        .we      (push_c),
        .wr_addr (wr_ptr),
        .wr_data (In_Data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign Count    = count;
    // Head word is masked to zero while empty.
    assign Out_Data = Out_Valid ? rd_data : '0;

endmodule : output_data_buffer

// File: tb/tb_output_data_buffer.sv
// Directed bench for output_data_buffer with a queue-based reference model.
module tb_output_data_buffer;

    localparam int DEPTH = 8;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] In_Data;
    logic        In_Write;
    logic        In_Full;
    logic [15:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [3:0]  Count;
    logic        Overflow;
    logic        Clear;
`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
    logic [7:0]  Drop_Count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    output_data_buffer dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .In_Data   (In_Data),
        .In_Write  (In_Write),
        .In_Full   (In_Full),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Count     (Count),
        .Overflow  (Overflow),
`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
        .Drop_Count(Drop_Count),
`endif
        .Clear     (Clear)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus sticky/saturating drop bookkeeping.
    logic [15:0] mq[$];
    bit          m_ovf   = 1'b0;
    int          m_drops = 0;
    bit          m_pop;
    bit          m_acc;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (Clear) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            m_pop = (mq.size() != 0) && Out_Ready;
            m_acc = In_Write && ((mq.size() < DEPTH) || m_pop);
            if (In_Write && !m_acc) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(In_Data);
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge Clock) begin
        chk("count",     int'(Count),     mq.size());
        chk("out_valid", int'(Out_Valid), int'(mq.size() != 0));
        chk("out_data",  int'(Out_Data),  (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("in_full",   int'(In_Full),   int'(mq.size() == DEPTH));
        chk("overflow",  int'(Overflow),  int'(m_ovf));
`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
        chk("drop_count", int'(Drop_Count), m_drops);
`endif
    end

    // One clock of stimulus, applied at a falling edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic c);
        In_Write  = w;
        In_Data   = d;
        Out_Ready = r;
        Clear     = c;
        @(negedge Clock);
    endtask

    task automatic fill(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, base + 16'(i), 1'b0, 1'b0);
    endtask

    logic [15:0] exp3 [8];

    initial begin
        In_Write  = 1'b0;
        In_Data   = '0;
        Out_Ready = 1'b0;
        Clear     = 1'b0;
        Reset_n   = 1'b1;
        #1 Reset_n = 1'b0;
        @(negedge Clock);
        chk("rst_count", int'(Count), 0);
        chk("rst_valid", int'(Out_Valid), 0);
        chk("rst_data",  int'(Out_Data), 0);
        chk("rst_full",  int'(In_Full), 0);
        chk("rst_ovf",   int'(Overflow), 0);
        Reset_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

        // Three writes held, then drained in order.
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        chk("t1_latency_data", int'(Out_Data), 'h0001);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0);
        chk("t1_count", int'(Count), 3);
        chk("t1_valid", int'(Out_Valid), 1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t1_hold", int'(Out_Data), 'h0001);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pop", int'(Out_Data), 1 + i);
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("t1_empty_count", int'(Count), 0);
        chk("t1_empty_data",  int'(Out_Data), 0);

        // Fill, drop one, drain.
        fill(16'h00A0, 8);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
        chk("t2_full", int'(In_Full), 1);
        chk("t2_ovf",  int'(Overflow), 1);
        chk("t2_count", int'(Count), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", int'(Out_Data), 'hA0 + i);
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("t2_empty", int'(Count), 0);

        // Push and pop together at full.
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3_ovf_cleared", int'(Overflow), 0);
        fill(16'h00B0, 8);
        cyc(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("t3_count", int'(Count), 8);
        chk("t3_ovf", int'(Overflow), 0);
        for (int i = 0; i < 8; i++) exp3[i] = (i < 7) ? 16'h00B1 + 16'(i) : 16'h1234;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", int'(Out_Data), int'(exp3[i]));
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Streaming through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            chk("t4_stream", int'(Out_Data), 'h100 + i);
            chk("t4_count", int'(Count), 1);
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4_empty", int'(Count), 0);

        // Clear beats a concurrent write and pop.
        fill(16'h00C0, 8);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t5_count5", int'(Count), 5);
        chk("t5_ovf_set", int'(Overflow), 1);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("t5_count", int'(Count), 0);
        chk("t5_ovf", int'(Overflow), 0);
        chk("t5_valid", int'(Out_Valid), 0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t5_no_beef", int'(Out_Valid), 0);

        // Asynchronous reset mid-cycle.
        fill(16'h00D0, 8);
        cyc(1'b1, 16'h00FF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        In_Write  = 1'b0;
        Out_Ready = 1'b0;
        chk("t6_count4", int'(Count), 4);
        #2 Reset_n = 1'b0;
        #1;
        chk("t6_count", int'(Count), 0);
        chk("t6_valid", int'(Out_Valid), 0);
        chk("t6_full",  int'(In_Full), 0);
        chk("t6_ovf",   int'(Overflow), 0);
        chk("t6_data",  int'(Out_Data), 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);

`ifdef OUTPUT_BUFFER_DROP_COUNT_EN
        // Saturating drop counter.
        fill(16'h00E0, 8);
        for (int i = 0; i < 300; i++) cyc(1'b1, 16'h0F00, 1'b0, 1'b0);
        chk("t7_drop_sat", int'(Drop_Count), 255);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t7_drop_clr", int'(Drop_Count), 0);
`endif

        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_output_data_buffer
